predistort_taps_loader: RTL
===========================

Name: predistort_taps_loader

Overview:
Upstream feeder for the predistort block's taps AXI-stream port. Software writes a tap table of 2^DEPTH entries over the settings bus. A commit then replays the whole table as one AXI-stream packet (taps_tdata/tlast/tvalid/tready), with tlast on the final entry. The table is held locally, so a reload only needs another commit.

Parameters:
WIDTH, 16, tap width in bits; must match predistort WIDTH.
DEPTH, 7, log2 of table entries; must match predistort DEPTH (7 gives 128 taps).
BASE, 8'd0, settings-bus base address.
AUTO_COMMIT, 0, 1 = start a stream automatically when the write pointer wraps from 2^DEPTH-1 to 0.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-low; reset=0 resets all state.
clear  in  1  synchronous, active-high; same effect as reset except table contents are kept.
set_stb  in  1  settings-bus write strobe.
set_addr  in  8  settings-bus address.
set_data  in  32  settings-bus data.
taps_tdata  out  WIDTH  tap value.
taps_tlast  out  1  high on entry 2^DEPTH-1.
taps_tvalid  out  1  stream valid.
taps_tready  in  1  predistort ready.
busy  out  1  high while streaming.
wr_ptr  out  DEPTH  next table write index.
dropped  out  1  one-cycle pulse when a tap write or commit is rejected.

Behaviour:
- Registers:
  - BASE+0 TAP: data[WIDTH-1:0] is written to table[wr_ptr]; wr_ptr increments modulo 2^DEPTH.
  - BASE+1 CTRL: bit0 = commit; bit1 = zero wr_ptr. If both bits are set, the pointer zeroes first and the stream starts in the same cycle.
- Writes to other addresses are ignored.
- Reset/clear values: taps_tvalid=0, taps_tlast=0, busy=0, wr_ptr=0, dropped=0, rd_ptr=0, state=IDLE. taps_tdata shows table[0] (value don't-care after power-up).
- Table: 2^DEPTH x WIDTH distributed RAM with a synchronous write and a combinational read. A write in cycle N is readable in cycle N+1.
- FSM states: IDLE, STREAM.
  - IDLE -> STREAM on a commit write (or an AUTO_COMMIT wrap). rd_ptr is set to 0.
  - taps_tvalid=1 from the cycle after the commit strobe (latency 1).
  - STREAM: taps_tdata=table[rd_ptr]; taps_tlast=(rd_ptr==2^DEPTH-1).
  - On taps_tvalid&&taps_tready, rd_ptr increments. If tlast is on that beat, go to IDLE; taps_tvalid is 0 on the next cycle.
  - With tready held high, a stream is exactly 2^DEPTH consecutive beats.
- busy=1 exactly when state==STREAM.
- Backpressure: while taps_tready=0, tdata, tlast and tvalid hold stable (AXI rule).
- Writes while busy:
  - TAP writes are rejected: table and wr_ptr are unchanged, dropped pulses.
  - CTRL commit is rejected: dropped pulses, the stream is not restarted.
  - CTRL bit1 is still honoured.
- AUTO_COMMIT: a wrap that occurs while busy is impossible, because TAP writes are rejected while busy.
- clear or reset mid-stream: tvalid drops the next cycle (asynchronously on reset) and the FSM returns to IDLE. The truncated packet is accepted behaviour; predistort is cleared alongside.
- Back-to-back commit: a commit accepted in the cycle immediately after the tlast beat starts a new stream (state is already IDLE).

Decomposition:
- Shared package:
  - register offsets TAP_REG=0 and CTRL_REG=1;
  - CTRL bit positions CTRL_COMMIT=0 and CTRL_PTR_RST=1;
  - FSM state enum {IDLE, STREAM}.
- One sub-module, predistort_tap_ram: parameterised WIDTH/DEPTH, one synchronous write port, one asynchronous read port, no reset on the array.
- The FSM and settings decode stay in the top module.

Test Plan:
- Basic load (DEPTH=3, BASE=64, tready=1): write TAP 0x0100..0x0107, then CTRL=1 -> 8 beats of 0x0100..0x0107 on consecutive cycles, tlast only on 0x0107, busy falls after it, wr_ptr=0.
- Backpressure: as above, tready toggled 1,0,0,1... -> every value is delivered exactly once, in order, and tdata is stable while stalled.
- Write while busy:
  - TAP 0xBEEF during the stream -> dropped pulses once, wr_ptr unchanged;
  - a second commit -> streams 0x0100..0x0107 again, with no 0xBEEF.
- Pointer reset / AUTO_COMMIT=1:
  - write 3 taps, CTRL=2 -> wr_ptr=0;
  - write 8 taps 0x0200..0x0207 -> a stream starts without a commit, the cycle after the 8th write.
- Mid-stream abort: pulse clear after beat 3 -> taps_tvalid=0 the next cycle, busy=0; a later commit streams from entry 0 with the table intact.
- Async reset: drive reset=0 between clock edges mid-stream -> taps_tvalid, busy and wr_ptr are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/predistort_taps_loader_pkg.sv
// Shared definitions for the predistort tap-table loader.
// Holds the register map, the CTRL bit positions and the streaming FSM states.
package predistort_taps_loader_pkg;

    localparam logic [7:0] TAP_REG  = 8'd0;
    localparam logic [7:0] CTRL_REG = 8'd1;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_PTR_RST = 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/predistort_taps_loader_ram.sv
// Tap table storage: one synchronous write port and one combinational read port.
// The array is not reset, so its contents survive a clear.
module predistort_tap_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/predistort_taps_loader.sv
// Loads a tap table over the settings bus and replays it as one AXI-stream
// packet per commit, with tlast on the final table entry.
module predistort_taps_loader
    import predistort_taps_loader_pkg::*;
#(
    parameter int         WIDTH       = 16,
    parameter int         DEPTH       = 7,
    parameter logic [7:0] BASE        = 8'd0,
    parameter bit         AUTO_COMMIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [WIDTH-1:0] taps_tdata,
    output logic             taps_tlast,
    output logic             taps_tvalid,
    input  logic             taps_tready,
    output logic             busy,
    output logic [DEPTH-1:0] wr_ptr,
    output logic             dropped
);

    localparam logic [7:0]       TAP_ADDR  = BASE + TAP_REG;
    localparam logic [7:0]       CTRL_ADDR = BASE + CTRL_REG;
    localparam logic [DEPTH-1:0] LAST_IDX  = '1;

    state_t           state;
    state_t           state_next;
    logic [DEPTH-1:0] rd_ptr;

    logic tap_wr;
    logic ctrl_wr;
    logic tap_accept;
    logic commit_req;
    logic ptr_rst;
    logic wrap;
    logic start;
    logic reject;
    logic beat;
    logic unused_bits;

    assign tap_wr     = set_stb && (set_addr == TAP_ADDR);
    assign ctrl_wr    = set_stb && (set_addr == CTRL_ADDR);
    assign commit_req = ctrl_wr && set_data[CTRL_COMMIT];
    assign ptr_rst    = ctrl_wr && set_data[CTRL_PTR_RST];
    assign tap_accept = tap_wr && !busy && !clear;
    assign wrap       = AUTO_COMMIT && tap_accept && (wr_ptr == LAST_IDX);
    assign start      = !busy && (commit_req || wrap);
    assign reject     = busy && (tap_wr || commit_req);
    assign beat       = taps_tvalid && taps_tready;

    assign busy        = (state == STREAM);
    assign taps_tvalid = busy;
    assign taps_tlast  = busy && (rd_ptr == LAST_IDX);

    // upper settings-bus bits carry nothing for this block
    assign unused_bits = ^set_data[31:WIDTH];

    predistort_tap_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (tap_accept),
        .waddr (wr_ptr),
        .wdata (set_data[WIDTH-1:0]),
        .raddr (rd_ptr),
        .rdata (taps_tdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (beat && taps_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // pointer-reset takes priority so bit1+bit0 streams from a zeroed write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dropped <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dropped <= 1'b0;
        end else begin
            dropped <= reject;
            if (ptr_rst) begin
                wr_ptr <= '0;
            end else if (tap_accept) begin
                wr_ptr <= wr_ptr + DEPTH'(1);
            end
            if (start) begin
                rd_ptr <= '0;
            end else if (beat) begin
                rd_ptr <= rd_ptr + DEPTH'(1);
            end
        end
    end

endmodule
